// File: rtl/mult_seq_signed.sv
// Iterative radix-2 Booth signed multiplier with START/BUSY/DONE handshake and
// a fixed-point output stage (round half up, arithmetic shift, saturate).
// One Booth step per clock; WIDTH steps per product plus one FIN cycle.
module mult_seq_signed #(
    parameter int WIDTH      = 6,
    parameter int OUT_WIDTH  = 12,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [WIDTH-1:0]     DATA_A,
    input  logic [WIDTH-1:0]     DATA_B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [OUT_WIDTH-1:0] Q,
    output logic                 SAT
);

    // Step counter only needs to reach WIDTH-1.
    localparam int CW = $clog2(WIDTH + 1);
    // Rounding/saturation is done one bit wider than the product so the
    // rounding add can never wrap.
    localparam int PW = 2 * WIDTH + 1;
    localparam int HS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam logic signed [PW-1:0] HALF = (FRAC_SHIFT > 0) ? (PW'(1) << HS) : '0;
    localparam logic signed [PW-1:0] QMAX = (PW'(1) << (OUT_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] QMIN = ~QMAX;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       acc_q, acc_d;      // one guard bit: subtracting -2^(W-1) must not overflow
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mult_q, mult_d;
    logic                 bm1_q, bm1_d;      // Booth b_-1 bit
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] q_q, q_d;
    logic                 sat_q, sat_d;

    logic                 accept, last_step;
    logic [WIDTH:0]       a_ext, acc_sum, step_acc;
    logic [WIDTH-1:0]     step_mult;
    logic [2*WIDTH-1:0]   product;
    logic signed [PW-1:0] p_ext, r_full;
    logic [OUT_WIDTH-1:0] out_q;
    logic                 out_sat;

    assign accept    = (state_q == S_IDLE) && START;
    assign last_step = (state_q == S_CALC) && (cnt_q == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: IDLE -> CALC -> FIN -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_CALC;
            S_CALC:  if (last_step) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; DONE is exactly the FIN cycle.
    always_comb begin
        BUSY = (state_q != S_IDLE);
        DONE = (state_q == S_FIN);
    end

    // One Booth step: add/subtract multiplicand, then arithmetic shift of {acc, mult, b_-1}.
    always_comb begin
        a_ext   = {mcand_q[WIDTH-1], mcand_q};
        acc_sum = acc_q;
        case ({mult_q[0], bm1_q})
            2'b01:   acc_sum = acc_q + a_ext;
            2'b10:   acc_sum = acc_q - a_ext;
            default: acc_sum = acc_q;
        endcase
        step_acc  = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        step_mult = {acc_sum[0], mult_q[WIDTH-1:1]};
        // After the final step the low 2*WIDTH bits hold the exact product.
        product   = {step_acc[WIDTH-1:0], step_mult};
    end

    // Output stage on the post-final-step product: round half up, shift, saturate.
    always_comb begin
        p_ext  = {product[2*WIDTH-1], product};
        r_full = (p_ext + HALF) >>> FRAC_SHIFT;
        if (r_full > QMAX) begin
            out_q   = QMAX[OUT_WIDTH-1:0];
            out_sat = 1'b1;
        end else if (r_full < QMIN) begin
            out_q   = QMIN[OUT_WIDTH-1:0];
            out_sat = 1'b1;
        end else begin
            out_q   = r_full[OUT_WIDTH-1:0];
            out_sat = 1'b0;
        end
    end

    // Datapath next state: capture on accept, step in CALC, publish result on entry to FIN.
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        bm1_d   = bm1_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        sat_d   = sat_q;
        if (accept) begin
            acc_d   = '0;
            mcand_d = DATA_A;
            mult_d  = DATA_B;
            bm1_d   = 1'b0;
            cnt_d   = '0;
        end else if (state_q == S_CALC) begin
            acc_d  = step_acc;
            mult_d = step_mult;
            bm1_d  = mult_q[0];
            cnt_d  = cnt_q + CW'(1);
        end
        if (last_step) begin
            q_d   = out_q;
            sat_d = out_sat;
        end
    end

    // Datapath registers; reset discards any operation in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            bm1_q   <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            bm1_q   <= bm1_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sat_q   <= sat_d;
        end
    end

    assign Q   = q_q;
    assign SAT = sat_q;

endmodule

// File: tb/tb_mult_seq_signed.sv
// Directed bench for mult_seq_signed: default build (6x6 -> 12) and a
// fixed-point build (8x8 -> 8, shift 7). Inputs driven and outputs sampled on negedge.
module tb_mult_seq_signed;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST, START0, START1;
    logic [5:0] A0, B0;
    logic [7:0] A1, B1;
    logic       BUSY0, DONE0, SAT0, BUSY1, DONE1, SAT1;
    logic [11:0] Q0;
    logic [7:0]  Q1;

    int n_chk  = 0;
    int n_fail = 0;

    mult_seq_signed u_def (
        .CLK(CLK), .RST(RST), .START(START0), .DATA_A(A0), .DATA_B(B0),
        .BUSY(BUSY0), .DONE(DONE0), .Q(Q0), .SAT(SAT0)
    );

    mult_seq_signed #(.WIDTH(8), .OUT_WIDTH(8), .FRAC_SHIFT(7)) u_fx (
        .CLK(CLK), .RST(RST), .START(START1), .DATA_A(A1), .DATA_B(B1),
        .BUSY(BUSY1), .DONE(DONE1), .Q(Q1), .SAT(SAT1)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation from IDLE (called at a negedge), wait for DONE with a bound,
    // return result and latency in negedges after the accepting edge, then step to IDLE.
    task automatic op(input bit sel, input int a, input int b,
                      output int q, output int sat, output int lat);
        if (!sel) begin A0 = 6'(a); B0 = 6'(b); START0 = 1'b1; end
        else      begin A1 = 8'(a); B1 = 8'(b); START1 = 1'b1; end
        @(negedge CLK);
        START0 = 1'b0;
        START1 = 1'b0;
        lat = 1;
        while (!(sel ? DONE1 : DONE0) && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        if (!sel) begin q = 32'($signed(Q0)); sat = 32'(SAT0); end
        else      begin q = 32'($signed(Q1)); sat = 32'(SAT1); end
        @(negedge CLK);
    endtask

    int q, sat, lat, seen, guard;

    initial begin
        RST = 1'b1; START0 = 1'b0; START1 = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", 32'(BUSY0), 0);
        chk("rst_done", 32'(DONE0), 0);
        chk("rst_q", 32'(Q0), 0);
        chk("rst_sat", 32'(SAT0), 0);
        chk("rst_q_fx", 32'(Q1), 0);
        RST = 1'b0;
        @(negedge CLK);

        // Corners, default build.
        op(0, -32, -32, q, sat, lat); chk("c_mm_q", q, 1024); chk("c_mm_sat", sat, 0); chk("c_mm_lat", lat, 7);
        op(0, -32,  31, q, sat, lat); chk("c_mp_q", q, -992); chk("c_mp_sat", sat, 0);
        op(0,   0,  -1, q, sat, lat); chk("c_z_q", q, 0);

        // Fixed-point build: round half up, saturate.
        op(1,   64,   64, q, sat, lat); chk("fx_64_q", q, 32);   chk("fx_64_sat", sat, 0); chk("fx_lat", lat, 9);
        op(1, -128, -128, q, sat, lat); chk("fx_mm_q", q, 127);  chk("fx_mm_sat", sat, 1);
        op(1, -128,  127, q, sat, lat); chk("fx_mp_q", q, -127); chk("fx_mp_sat", sat, 0);
        op(1,    1,   64, q, sat, lat); chk("fx_half_q", q, 1);  chk("fx_half_sat", sat, 0);

        // START held high: 7 busy cycles, DONE in the 7th, one idle cycle, re-accept.
        A0 = 6'(5); B0 = 6'(-7); START0 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge CLK);
            chk("hs_busy", 32'(BUSY0), ((i % 8) < 7) ? 1 : 0);
            chk("hs_done", 32'(DONE0), ((i % 8) == 6) ? 1 : 0);
            if ((i % 8) == 6) chk("hs_q", 32'($signed(Q0)), -35);
        end
        START0 = 1'b0;
        @(negedge CLK);

        // Operands and START scrambled while busy: result uses captured values.
        A0 = 6'(13); B0 = 6'(-9); START0 = 1'b1;
        @(negedge CLK);
        guard = 0;
        while (!DONE0 && guard < 20) begin
            A0 = 6'($urandom); B0 = 6'($urandom); START0 = 1'($urandom);
            @(negedge CLK);
            guard++;
        end
        START0 = 1'b0;
        chk("chg_done_seen", 32'(DONE0), 1);
        chk("chg_q", 32'($signed(Q0)), -117);
        @(negedge CLK);

        // Reset in the 3rd CALC cycle discards the operation.
        A0 = 6'(7); B0 = 6'(7); START0 = 1'b1;
        @(negedge CLK);
        START0 = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("mr_busy", 32'(BUSY0), 0);
        chk("mr_done", 32'(DONE0), 0);
        chk("mr_q", 32'(Q0), 0);
        chk("mr_sat", 32'(SAT0), 0);
        seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE0) seen++;
        end
        chk("mr_no_done", seen, 0);
        op(0, -3, 11, q, sat, lat); chk("mr_new_q", q, -33); chk("mr_new_lat", lat, 7);

        // Exhaustive sweep, default build.
        for (int a = -32; a < 32; a++) begin
            for (int b = -32; b < 32; b++) begin
                op(0, a, b, q, sat, lat);
                chk("sw_q", q, a * b);
                chk("sw_sat", sat, 0);
                chk("sw_lat", lat, 7);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
